// File: rtl/spi_master_if.sv
// Pin-level and handshake bundle for the byte-wide SPI master.
// The master modport is the controller side; slave is the opposite end.
interface spi_master_if;
  logic       start;
  logic [7:0] txd_data;
  logic       busy;
  logic       done;
  logic [7:0] rxd_data;
  logic       CS_N;
  logic       SCK;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, txd_data, MISO,
    output busy, done, rxd_data, CS_N, SCK, MOSI
  );

  modport slave (
    output start, txd_data, MISO,
    input  busy, done, rxd_data, CS_N, SCK, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0), MSB-first, byte-wide SPI master.
// SCK is derived from sys_clk with a half-period of CLK_DIV cycles; every
// output is registered so there is no combinational input-to-output path.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic          sys_clk,
  input  logic          rst,
  spi_master_if.master  bus
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  TICK_VAL = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [6:0]       tx_sh;   // bits still to send after the one on MOSI
  logic [7:0]       rx_sh;
  logic             tick;

  // One tick per SCK half-period; only meaningful outside IDLE.
  assign tick = (div_cnt == TICK_VAL);

  // Frame sequencer: divider, shift registers and all registered outputs.
  // NOTE: asynchronous reset returns every output to its idle value at once,
  // so an aborted frame never produces done or touches rxd_data.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.rxd_data  <= 8'h00;
      bus.CS_N      <= 1'b1;
      bus.SCK       <= 1'b0;
      bus.MOSI      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge values of the shift registers and counters.
      bus.done <= 1'b0;
      if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      end

      unique case (state)
        IDLE: begin
          div_cnt <= '0;
          if (bus.start) begin
            tx_sh    <= bus.txd_data[6:0];
            bus.MOSI <= bus.txd_data[7];
            bit_cnt  <= '0;
            bus.CS_N <= 1'b0;
            bus.busy <= 1'b1;
            state    <= SETUP;
          end
        end

        SETUP: begin
          // First rising edge samples MISO just like the ones in XFER.
          if (tick) begin
            bus.SCK <= 1'b1;
            rx_sh   <= {rx_sh[6:0], bus.MISO};
            bit_cnt <= bit_cnt + 4'd1;
            state   <= XFER;
          end
        end

        XFER: begin
          if (tick) begin
            if (!bus.SCK) begin
              bus.SCK <= 1'b1;
              rx_sh   <= {rx_sh[6:0], bus.MISO};
              bit_cnt <= bit_cnt + 4'd1;
            end else begin
              bus.SCK <= 1'b0;
              if (bit_cnt == 4'd8) begin
                bus.MOSI <= 1'b0;
                state    <= HOLD;
              end else begin
                bus.MOSI <= tx_sh[6];
                tx_sh    <= {tx_sh[5:0], 1'b0};
              end
            end
          end
        end

        HOLD: begin
          if (tick) begin
            bus.CS_N     <= 1'b1;
            bus.rxd_data <= rx_sh;
            bus.done     <= 1'b1;
            state        <= GAP;
          end
        end

        GAP: begin
          if (tick) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (H=4 and H=2) share one clock and reset.
// Each frame is observed cycle by cycle from the first CS_N-low cycle and
// compared against timing and data derived from the frame rules.
module tb_spi_master;

  localparam int NONE = 1 << 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v [2];
  logic [7:0] txd_v   [2];
  logic       loop_v  [2];
  logic       miso_v  [2];

  logic       busy_w [2];
  logic       done_w [2];
  logic [7:0] rxd_w  [2];
  logic       cs_n_w [2];
  logic       sck_w  [2];
  logic       mosi_w [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int H = (g == 0) ? 4 : 2;
    spi_master_if bus ();
    assign bus.start    = start_v[g];
    assign bus.txd_data = txd_v[g];
    assign bus.MISO     = loop_v[g] ? bus.MOSI : miso_v[g];
    assign busy_w[g]    = bus.busy;
    assign done_w[g]    = bus.done;
    assign rxd_w[g]     = bus.rxd_data;
    assign cs_n_w[g]    = bus.CS_N;
    assign sck_w[g]     = bus.SCK;
    assign mosi_w[g]    = bus.MOSI;
    spi_master #(.CLK_DIV(H)) u_dut (
      .sys_clk (clk),
      .rst     (rst),
      .bus     (bus.master)
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int h_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  // Observation record of the last run.
  int         ob_rise_cyc [$];
  logic       ob_mosi     [$];
  int         ob_done_cyc [$];
  logic [7:0] ob_rx       [$];
  int         ob_busy_fall[$];
  int         ob_gap      [$];
  int         ob_csn_low;
  int         ob_done_wide;
  logic       ob_first_csn;
  logic       ob_rst_cs, ob_rst_sck, ob_rst_busy, ob_rst_done;
  logic [7:0] next_tx     [$];

  // Start a frame on DUT d and watch it for ncycles cycles (cycle 0 = first
  // CS_N-low cycle). The bench acts as slave returning sb, or loops MOSI back.
  task automatic run(input int d, input logic [7:0] tx, input logic [7:0] sb,
                     input bit lb, input int nheld, input int pulse_at,
                     input int rst_at, input int ncycles);
    logic psck, pdone, pbusy;
    int   rif, hi_run, nd;
    bit   seen_low;
    ob_rise_cyc.delete(); ob_mosi.delete(); ob_done_cyc.delete();
    ob_rx.delete(); ob_busy_fall.delete(); ob_gap.delete();
    ob_csn_low = 0; ob_done_wide = 0; ob_first_csn = 1'bx;
    psck = 1'b0; pdone = 1'b0; pbusy = 1'b0;
    rif = 0; hi_run = 0; nd = 0; seen_low = 1'b0;
    @(negedge clk);
    loop_v[d]  = lb;
    miso_v[d]  = sb[7];
    txd_v[d]   = tx;
    start_v[d] = 1'b1;
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      if (c == 0) ob_first_csn = cs_n_w[d];
      if (sck_w[d] && !psck) begin
        ob_rise_cyc.push_back(c);
        ob_mosi.push_back(mosi_w[d]);
        rif++;
      end
      if (done_w[d]) begin
        ob_done_cyc.push_back(c);
        ob_rx.push_back(rxd_w[d]);
        if (pdone) ob_done_wide++;
        nd++;
        if (next_tx.size() > 0) txd_v[d] = next_tx.pop_front();
        if (nd >= nheld) start_v[d] = 1'b0;
      end
      if (!busy_w[d] && pbusy) ob_busy_fall.push_back(c);
      if (!cs_n_w[d]) begin
        ob_csn_low++;
        if (seen_low && hi_run > 0) ob_gap.push_back(hi_run);
        hi_run   = 0;
        seen_low = 1'b1;
      end else begin
        if (seen_low) hi_run++;
        rif = 0;
      end
      miso_v[d] = (rif < 8) ? sb[7 - rif] : 1'b0;
      if (c == 0 && nheld <= 1) start_v[d] = 1'b0;
      if (c == pulse_at) start_v[d] = 1'b1;
      if (c == pulse_at + 1) start_v[d] = 1'b0;
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        ob_rst_cs   = cs_n_w[d];
        ob_rst_sck  = sck_w[d];
        ob_rst_busy = busy_w[d];
        ob_rst_done = done_w[d];
      end
      if (c == rst_at + 2) rst = 1'b0;
      psck  = sck_w[d];
      pdone = done_w[d];
      pbusy = busy_w[d];
    end
  endtask

  // Compare one observed single frame against the expected behaviour.
  task automatic verify_frame(input string tag, input int d, input logic [7:0] tx,
                              input logic [7:0] exp_rx, input int exp_done,
                              input int exp_bf);
    int         h;
    logic [7:0] mb;
    h  = h_of(d);
    mb = 8'h00;
    check({tag, ".first_csn"}, int'(ob_first_csn), 0);
    check({tag, ".rises"}, ob_rise_cyc.size(), 8);
    for (int k = 0; k < ob_rise_cyc.size() && k < 8; k++) begin
      check($sformatf("%s.rise%0d_cyc", tag, k), ob_rise_cyc[k], h * (2 * k + 1));
      mb = {mb[6:0], ob_mosi[k]};
    end
    check({tag, ".mosi_bits"}, int'(mb), int'(tx));
    check({tag, ".done_n"}, ob_done_cyc.size(), 1);
    check({tag, ".done_cyc"}, (ob_done_cyc.size() > 0) ? ob_done_cyc[0] : -1, exp_done);
    check({tag, ".rx_at_done"}, (ob_rx.size() > 0) ? int'(ob_rx[0]) : -1, int'(exp_rx));
    check({tag, ".busy_fall"}, (ob_busy_fall.size() > 0) ? ob_busy_fall[0] : -1, exp_bf);
    check({tag, ".csn_low"}, ob_csn_low, 17 * h);
    check({tag, ".done_wide"}, ob_done_wide, 0);
    check({tag, ".rxd_held"}, int'(rxd_w[d]), int'(exp_rx));
  endtask

  typedef struct {
    int         d;
    logic [7:0] tx;
    logic [7:0] sb;
    bit         lb;
    logic [7:0] exp_rx;
    int         exp_done;
    int         exp_bf;
  } vec_t;

  initial begin
    vec_t       tbl [4];
    int         d, h;
    logic [7:0] tx, sb;
    bit         lb;

    tbl[0] = '{d: 0, tx: 8'hA5, sb: 8'h00, lb: 1'b1, exp_rx: 8'hA5, exp_done: 68, exp_bf: 72};
    tbl[1] = '{d: 0, tx: 8'hF0, sb: 8'h3C, lb: 1'b0, exp_rx: 8'h3C, exp_done: 68, exp_bf: 72};
    tbl[2] = '{d: 1, tx: 8'h5A, sb: 8'h00, lb: 1'b1, exp_rx: 8'h5A, exp_done: 34, exp_bf: 36};
    tbl[3] = '{d: 1, tx: 8'h81, sb: 8'h7E, lb: 1'b0, exp_rx: 8'h7E, exp_done: 34, exp_bf: 36};

    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; txd_v[i] = 8'h00; loop_v[i] = 1'b0; miso_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values on both instances.
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d.cs_n", i), int'(cs_n_w[i]), 1);
      check($sformatf("rst%0d.sck", i),  int'(sck_w[i]), 0);
      check($sformatf("rst%0d.mosi", i), int'(mosi_w[i]), 0);
      check($sformatf("rst%0d.busy", i), int'(busy_w[i]), 0);
      check($sformatf("rst%0d.done", i), int'(done_w[i]), 0);
      check($sformatf("rst%0d.rxd", i),  int'(rxd_w[i]), 0);
    end

    // Reset at cycle 9H aborts the frame.
    run(0, 8'hA5, 8'h00, 1'b1, 1, NONE, 36, 76);
    check("abort.cs_n_now", int'(ob_rst_cs), 1);
    check("abort.sck_now",  int'(ob_rst_sck), 0);
    check("abort.busy_now", int'(ob_rst_busy), 0);
    check("abort.done_now", int'(ob_rst_done), 0);
    check("abort.no_done",  ob_done_cyc.size(), 0);
    check("abort.rxd",      int'(rxd_w[0]), 0);
    check("abort.idle_cs",  int'(cs_n_w[0]), 1);

    // Directed frames, the first doubling as the fresh start after reset.
    for (int i = 0; i < 4; i++) begin
      run(tbl[i].d, tbl[i].tx, tbl[i].sb, tbl[i].lb, 1, NONE, NONE, 18 * h_of(tbl[i].d) + 4);
      verify_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].tx, tbl[i].exp_rx,
                   tbl[i].exp_done, tbl[i].exp_bf);
    end

    // start held high for three loopback frames.
    next_tx.delete();
    next_tx.push_back(8'h80);
    next_tx.push_back(8'hFF);
    run(0, 8'h01, 8'h00, 1'b1, 3, NONE, NONE, 3 * (18 * 4 + 1) + 6);
    check("held.done_n", ob_done_cyc.size(), 3);
    for (int f = 0; f < 3 && f < ob_done_cyc.size(); f++) begin
      check($sformatf("held.done%0d_cyc", f), ob_done_cyc[f], 17 * 4 + f * (18 * 4 + 1));
      check($sformatf("held.rx%0d", f), int'(ob_rx[f]), (f == 0) ? 8'h01 : (f == 1) ? 8'h80 : 8'hFF);
    end
    check("held.gap_n", ob_gap.size(), 2);
    for (int gi = 0; gi < ob_gap.size(); gi++)
      check($sformatf("held.gap%0d", gi), ob_gap[gi], 4 + 1);
    check("held.done_wide", ob_done_wide, 0);
    check("held.csn_low", ob_csn_low, 3 * 17 * 4);

    // start pulsed mid-frame is ignored.
    run(0, 8'hC3, 8'h96, 1'b0, 1, 10, NONE, 2 * (18 * 4 + 1) + 10);
    check("pulse.done_n", ob_done_cyc.size(), 1);
    check("pulse.rx", (ob_rx.size() > 0) ? int'(ob_rx[0]) : -1, 8'h96);
    check("pulse.csn_low", ob_csn_low, 17 * 4);
    check("pulse.rxd_held", int'(rxd_w[0]), 8'h96);

    // Randomized frames against the reference rules.
    for (int r = 0; r < 8; r++) begin
      d  = int'($urandom_range(0, 1));
      h  = h_of(d);
      tx = 8'($urandom);
      sb = 8'($urandom);
      lb = 1'($urandom_range(0, 1));
      run(d, tx, sb, lb, 1, NONE, NONE, 18 * h + 4);
      verify_frame($sformatf("rnd%0d", r), d, tx, lb ? tx : sb, 17 * h, 18 * h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
